// File: rtl/ubm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ubm_pkg
//  Description : Shared definitions for the UART bus master: command codes,
//                controller state encoding and the frame byte-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package ubm_pkg;

    // Command bytes that open a frame
    localparam logic [7:0] CMD_W = 8'h57;  // 'W'
    localparam logic [7:0] CMD_R = 8'h52;  // 'R'

    // Byte counter spans one 4-byte field and wraps at the field end
    localparam int BCNT_W = 2;
    typedef logic [BCNT_W-1:0] bcnt_t;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ADDR  = 4'd1,
        S_DATA  = 4'd2,
        S_WR    = 4'd3,
        S_WWAIT = 4'd4,
        S_RD    = 4'd5,
        S_RWAIT = 4'd6,
        S_NAK   = 4'd7,
        S_SEND  = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ubm_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ubm_gap_timer
//  Description : Inter-byte gap timer. Loadable down-counter: reload arms it,
//                it counts down while enabled, and expired is flagged once
//                TIMEOUT cycles have elapsed since the last reload.
//  Ports       : clk      - system clock
//                resetn   - asynchronous active-low reset
//                en       - count enable (frame collection in progress)
//                reload   - restart the gap measurement (byte accepted)
//                expired  - gap has reached TIMEOUT while enabled
//  Revision    : 1.0 - initial release
// ============================================================================
module ubm_gap_timer #(
    parameter int TIMEOUT = 2_500_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic reload,
    output logic expired
);

    localparam int             c_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Reloaded value is one less than TIMEOUT: the count hits zero exactly
    // TIMEOUT cycles after the reload edge.
    localparam logic [c_W-1:0] c_LOAD = c_W'(TIMEOUT - 1);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (reload) begin
            r_count <= c_LOAD;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - c_W'(1);
        end
    end

    assign expired = en && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bus_master
//  Description : Bus initiator driven by a UART byte stream. Decodes
//                'W' A0..A3 D0..D3 (word write, reply ACK) and 'R' A0..A3
//                (word read, reply R0..R3), all fields LSB first. Any other
//                command byte is answered with NAK.
//  Ports       : clk, resetn           - clock, async active-low reset
//                rx_data/rx_valid      - received byte and its strobe
//                tx_data/tx_start      - byte to send and its start pulse
//                tx_busy               - transmitter busy
//                mem_addr/mem_wdata    - word address / write data
//                mem_wmask/mem_rstrb   - write enables / read strobe
//                mem_rdata             - read data
//                mem_rbusy/mem_wbusy   - read / write in progress
//                hold                  - this block owns the bus
//                overrun               - sticky: byte dropped while busy
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_master
    import ubm_pkg::*;
#(
    parameter int         TIMEOUT = 2_500_000,
    parameter logic [7:0] ACK     = 8'h06,
    parameter logic [7:0] NAK     = 8'h15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rbusy,
    input  logic        mem_wbusy,
    output logic        hold,
    output logic        overrun
);

    localparam bcnt_t c_LAST_IDX = '1;

    state_t      r_state;
    state_t      w_next;

    logic        r_is_write;   // latched command: 1 = write, 0 = read
    bcnt_t       r_cnt;        // field byte index, then reply byte index
    bcnt_t       r_last;       // index of the final reply byte
    logic [31:0] r_shift;      // field assembly, then reply byte queue
    logic [7:0]  r_tx_data;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_start_d;    // tx_start was issued last cycle
    logic        r_overrun;

    logic        w_collect;
    logic        w_expired;
    logic        w_tx_go;
    logic        w_is_cmd;

    assign w_collect = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_is_cmd  = (rx_data == CMD_W) || (rx_data == CMD_R);
    // Waiting one cycle after every start tolerates transmitters whose busy
    // flag rises a cycle late.
    assign w_tx_go   = (r_state == S_SEND) && !tx_busy && !r_start_d;

    ubm_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk     (clk),
        .resetn  (resetn),
        .en      ((r_state == S_ADDR) || (r_state == S_DATA)),
        .reload  (rx_valid && w_collect),
        .expired (w_expired)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded strobes. Strobes come straight from the
    // state register so that reset removes them without waiting for a clock.
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        mem_wmask = 4'h0;
        mem_rstrb = 1'b0;
        tx_start  = 1'b0;
        hold      = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    w_next = w_is_cmd ? S_ADDR : S_NAK;
                end
            end
            S_ADDR: begin
                // An arriving byte wins over an expiring gap timer
                if (rx_valid) begin
                    if (r_cnt == c_LAST_IDX) begin
                        w_next = r_is_write ? S_DATA : S_RD;
                    end
                end else if (w_expired) begin
                    w_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    if (r_cnt == c_LAST_IDX) begin
                        w_next = S_WR;
                    end
                end else if (w_expired) begin
                    w_next = S_IDLE;
                end
            end
            S_WR: begin
                mem_wmask = 4'hF;
                w_next    = S_WWAIT;
            end
            S_WWAIT: begin
                if (!mem_wbusy) begin
                    w_next = S_SEND;
                end
            end
            S_RD: begin
                mem_rstrb = 1'b1;
                w_next    = S_RWAIT;
            end
            S_RWAIT: begin
                if (!mem_rbusy) begin
                    w_next = S_SEND;
                end
            end
            S_NAK: begin
                w_next = S_SEND;
            end
            S_SEND: begin
                tx_start = w_tx_go;
                if (w_tx_go && (r_cnt == r_last)) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: field assembly, address/data commit, reply sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_is_write <= 1'b0;
            r_cnt      <= '0;
            r_last     <= '0;
            r_shift    <= '0;
            r_tx_data  <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_start_d  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_start_d <= w_tx_go;

            if (rx_valid && !w_collect) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        r_is_write <= (rx_data == CMD_W);
                        r_cnt      <= '0;
                    end
                end
                S_ADDR: begin
                    // Bytes shift in from the top so A0 ends up in [7:0].
                    // mem_addr only changes once the whole field is in, so
                    // an abandoned frame leaves the previous address intact.
                    if (rx_valid) begin
                        r_shift <= {rx_data, r_shift[31:8]};
                        r_cnt   <= r_cnt + bcnt_t'(1);
                        if (r_cnt == c_LAST_IDX) begin
                            r_addr <= {rx_data, r_shift[31:10], 2'b00};
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        r_shift <= {rx_data, r_shift[31:8]};
                        r_cnt   <= r_cnt + bcnt_t'(1);
                        if (r_cnt == c_LAST_IDX) begin
                            r_wdata <= {rx_data, r_shift[31:8]};
                        end
                    end
                end
                S_WWAIT: begin
                    if (!mem_wbusy) begin
                        r_tx_data <= ACK;
                        r_last    <= '0;
                    end
                end
                S_RWAIT: begin
                    if (!mem_rbusy) begin
                        r_tx_data <= mem_rdata[7:0];
                        r_shift   <= {8'h00, mem_rdata[31:8]};
                        r_last    <= c_LAST_IDX;
                    end
                end
                S_NAK: begin
                    r_tx_data <= NAK;
                    r_last    <= '0;
                end
                S_SEND: begin
                    // Next byte is staged right after each start; the final
                    // byte stays on tx_data after it has been sent.
                    if (w_tx_go) begin
                        r_cnt <= r_cnt + bcnt_t'(1);
                        if (r_cnt != r_last) begin
                            r_tx_data <= r_shift[7:0];
                            r_shift   <= {8'h00, r_shift[31:8]};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign tx_data   = r_tx_data;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_master.sv
`timescale 1ns/1ps
module tb_uart_bus_master;

    localparam int c_TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_rbusy = 1'b0;
    logic        mem_wbusy = 1'b0;
    logic        hold;
    logic        overrun;

    always #5 clk = ~clk;

    uart_bus_master #(.TIMEOUT(c_TIMEOUT)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .mem_rbusy (mem_rbusy),
        .mem_wbusy (mem_wbusy),
        .hold      (hold),
        .overrun   (overrun)
    );

    // ---------------- scoreboard and reference memory ----------------
    typedef struct packed {
        logic        is_write;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    bus_t        bus_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] ref_mem [bit [31:0]];
    logic [31:0] dut_mem [bit [31:0]];

    int n_tests = 0;
    int n_fail  = 0;

    // model knobs
    int r_lat_cfg = -1;   // -1: random read latency
    int w_lat_cfg = -1;   // -1: random write latency
    bit tx_late   = 1'b0; // transmitter raises busy one cycle late

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [127:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0h, expected no event", name, act);
    endtask

    // ---------------- memory and transmitter models ----------------
    int rb_cnt = 0, wb_cnt = 0, tb_busy_cnt = 0, tx_dly = -1, tx_len = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                rb_cnt = 0; wb_cnt = 0; tb_busy_cnt = 0; tx_dly = -1;
            end else begin
                if (mem_rstrb)
                    rb_cnt = (r_lat_cfg >= 0) ? r_lat_cfg : int'($urandom_range(0, 3));
                if (mem_wmask == 4'hF) begin
                    dut_mem[mem_addr] = mem_wdata;
                    wb_cnt = (w_lat_cfg >= 0) ? w_lat_cfg : int'($urandom_range(0, 3));
                end
                if (tx_start) begin
                    tx_dly = tx_late ? 1 : 0;
                    tx_len = int'($urandom_range(1, 4));
                end
            end
            @(posedge clk);
            #1;
            mem_rbusy = (rb_cnt > 0);
            if (rb_cnt > 0) rb_cnt--;
            mem_wbusy = (wb_cnt > 0);
            if (wb_cnt > 0) wb_cnt--;
            if (tx_dly == 0) begin
                tb_busy_cnt = tx_len;
                tx_dly = -1;
            end else if (tx_dly > 0) begin
                tx_dly--;
            end
            tx_busy = (tb_busy_cnt > 0);
            if (tb_busy_cnt > 0) tb_busy_cnt--;
            mem_rdata = mem_rbusy ? 32'hBAD0_BAD0 :
                        (dut_mem.exists(mem_addr) ? dut_mem[mem_addr] : 32'h0);
        end
    end

    // ---------------- monitor ----------------
    logic prev_start = 1'b0;
    bus_t mon_e;

    always @(negedge clk) begin
        if (!resetn) begin
            prev_start = 1'b0;
        end else begin
            if (mem_wmask != 4'h0 || mem_rstrb) begin
                if (bus_q.size() == 0) begin
                    fail_now("bus_unexpected", {mem_wmask, mem_rstrb, mem_addr});
                end else begin
                    mon_e = bus_q.pop_front();
                    if (mon_e.is_write)
                        check("bus_write", {mem_wmask, mem_rstrb, mem_addr, mem_wdata},
                              {4'hF, 1'b0, mon_e.addr, mon_e.data});
                    else
                        check("bus_read", {mem_wmask, mem_rstrb, mem_addr},
                              {4'h0, 1'b1, mon_e.addr});
                end
            end
            if (tx_start) begin
                check("tx_start_protocol", {tx_busy, prev_start}, 2'b00);
                if (tx_q.size() == 0) fail_now("tx_unexpected", tx_data);
                else check("tx_byte", tx_data, tx_q.pop_front());
            end
            prev_start = tx_start;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (hold !== 1'b0 && n < 2000) begin @(posedge clk); #1; n++; end
        if (hold !== 1'b0) fail_now({name, "_hold_stuck"}, hold);
        check({name, "_drain"}, bus_q.size() + tx_q.size(), 0);
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] k);
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input int gap);
        logic [31:0] k = a & ~32'h3;
        bus_q.push_back({1'b1, k, d});
        ref_mem[k] = d;
        tx_q.push_back(8'h06);
        send_byte(8'h57, gap);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], gap);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], (i == 3) ? 0 : gap);
    endtask

    task automatic issue_read(input logic [31:0] a, input int gap);
        logic [31:0] k = a & ~32'h3;
        logic [31:0] v = ref_read(k);
        bus_q.push_back({1'b0, k, 32'h0});
        for (int i = 0; i < 4; i++) tx_q.push_back(v[8*i +: 8]);
        send_byte(8'h52, gap);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], (i == 3) ? 0 : gap);
    endtask

    task automatic do_bad(input logic [7:0] c);
        tx_q.push_back(8'h15);
        send_byte(c, 0);
        wait_idle("nak");
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_data"},   tx_data,   8'h00);
        check({tag, "_tx_start"},  tx_start,  1'b0);
        check({tag, "_mem_addr"},  mem_addr,  32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_mem_wmask"}, mem_wmask, 4'h0);
        check({tag, "_mem_rstrb"}, mem_rstrb, 1'b0);
        check({tag, "_hold"},      hold,      1'b0);
        check({tag, "_overrun"},   overrun,   1'b0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] base = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h0000_1000;
        return base | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0]  c;
        logic [31:0] a;
        int          n;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        resetn = 1'b1;
        @(posedge clk); #1;
        check_reset_values("post_reset");

        // directed write
        w_lat_cfg = 2;
        issue_write(32'h0000_0004, 32'hDEAD_BEEF, 0);
        wait_idle("write_dir");

        // read with 3-cycle busy
        r_lat_cfg = 3;
        issue_read(32'h0000_0004, 1);
        wait_idle("read_lat3");

        // low address bits ignored
        r_lat_cfg = 0;
        issue_read(32'h0000_0007, 0);
        wait_idle("read_align");
        check("addr_align", mem_addr, 32'h0000_0004);

        // unknown command
        do_bad(8'h41);

        // stalled write frame: timeout boundary
        send_byte(8'h57, 0);
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        repeat (c_TIMEOUT - 1) begin @(posedge clk); #1; end
        check("timeout_not_yet", hold, 1'b1);
        @(posedge clk); #1;
        check("timeout_idle", hold, 1'b0);
        check("timeout_addr_kept", mem_addr, 32'h0000_0004);
        repeat (5) begin @(posedge clk); #1; end
        check("timeout_no_reply", bus_q.size() + tx_q.size(), 0);
        issue_read(32'h0000_0004, 0);
        wait_idle("read_after_timeout");

        // extra bytes during reply
        check("overrun_clear", overrun, 1'b0);
        issue_read(32'h0000_0004, 0);
        n = 0;
        do begin @(negedge clk); n++; end while (tx_start !== 1'b1 && n < 500);
        if (tx_start !== 1'b1) fail_now("wait_tx_start", tx_start);
        @(posedge clk); #1;
        send_byte(8'h57, 0);
        send_byte(8'h52, 0);
        wait_idle("read_overrun");
        check("overrun_set", overrun, 1'b1);

        // late-busy transmitter
        tx_late = 1'b1;
        issue_write(32'h8000_0010, 32'h1234_5678, 1);
        wait_idle("write_late");
        issue_read(32'h8000_0010, 0);
        wait_idle("read_late");

        // randomized traffic
        r_lat_cfg = -1;
        w_lat_cfg = -1;
        for (int it = 0; it < 40; it++) begin
            tx_late = ($urandom_range(0, 1) != 0);
            a = rand_addr();
            case ($urandom_range(0, 4))
                0, 1: begin
                    issue_write(a, $urandom, int'($urandom_range(0, 2)));
                    wait_idle("rand_write");
                end
                2, 3: begin
                    issue_read(a, int'($urandom_range(0, 2)));
                    wait_idle("rand_read");
                end
                default: begin
                    do c = 8'($urandom_range(0, 255)); while (c == 8'h57 || c == 8'h52);
                    do_bad(c);
                end
            endcase
        end

        // reset during WWAIT
        tx_late   = 1'b0;
        w_lat_cfg = 12;
        issue_write(32'h0000_0020, 32'hCAFE_F00D, 0);
        n = 0;
        while (mem_wmask !== 4'hF && n < 100) begin @(negedge clk); n++; end
        if (mem_wmask !== 4'hF) fail_now("wait_wmask", mem_wmask);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wwait_hold", hold, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_values("async_reset");
        tx_q.delete();
        bus_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn    = 1'b1;
        w_lat_cfg = -1;
        @(posedge clk); #1;
        issue_read(32'h0000_0020, 1);
        wait_idle("read_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

- Bus initiator for the SoC memory bus, driven by a byte stream from the UART receiver.
- Decodes write/read command frames and issues word transactions with the same mem_addr/mem_wdata/mem_wmask/mem_rstrb/mem_rdata/busy signalling the CPU uses.
- Returns an acknowledge byte or read data through the UART transmitter.
- Sits beside the CPU; the SoC muxes the bus to this block while `hold` is high. Used for program loading and debug peek/poke.

## Interface
- `TIMEOUT`, 2_500_000: max clk cycles between bytes of one frame (100 ms at 25 MHz); on expiry the frame is discarded.
- `ACK`, 8'h06: response byte to a completed write.
- `NAK`, 8'h15: response byte to an unknown command.
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid.
- `tx_data`  out  8  byte to transmit.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_busy`  in  1  transmitter busy.
- `mem_addr`  out  32  word address; bits [1:0] always 0.
- `mem_wdata`  out  32  write data.
- `mem_wmask`  out  4  byte write enables; 4'hF or 4'h0.
- `mem_rstrb`  out  1  read strobe.
- `mem_rdata`  in  32  read data.
- `mem_rbusy`  in  1  read not yet complete.
- `mem_wbusy`  in  1  write not yet complete.
- `hold`  out  1  bridge owns the bus; high whenever state ≠ IDLE.
- `overrun`  out  1  sticky; a byte arrived while not collecting. Cleared only by reset.

## Operation
- Frame formats, all multi-byte fields LSB first:
  - Write: 'W' (8'h57), A0..A3, D0..D3 → one word write, reply `ACK`.
  - Read: 'R' (8'h52), A0..A3 → one word read, reply R0..R3 (LSB first).
  - Any other command byte: reply `NAK`, return to IDLE.
- States and transitions:
  - IDLE: `rx_valid` with 'W' or 'R' → ADDR (command latched). Any other byte → NAK.
  - ADDR: shift in 4 bytes. Then 'W' → DATA; 'R' → RD.
  - DATA: shift in 4 bytes → WR.
  - WR: `mem_wmask`=4'hF for exactly one cycle → WWAIT.
  - WWAIT: wait until `mem_wbusy`=0 → SEND, with one byte `ACK`.
  - RD: `mem_rstrb`=1 for exactly one cycle → RWAIT.
  - RWAIT: on the first cycle with `mem_rbusy`=0, latch `mem_rdata` → SEND, with 4 bytes.
  - NAK: → SEND, with one byte `NAK`.
  - SEND: pulse `tx_start` per byte; after the last byte → IDLE.
- Address byte A0 bits [1:0] are ignored; `mem_addr`[1:0] is driven to 0.
- Byte counter is 2 bits and wraps 3→0 at the field end.
- `mem_addr` and `mem_wdata` hold their assembled values between transactions.
- Gap timer runs in ADDR and DATA only; it reloads on each accepted byte. When it reaches `TIMEOUT`: go to IDLE, send no reply, assert no bus strobe.
- `rx_valid` in WR/WWAIT/RD/RWAIT/NAK/SEND: byte is dropped and `overrun` is set.
- `rx_valid` in IDLE/ADDR/DATA is always accepted. No byte is lost on the IDLE→ADDR edge.

## Timing
- Reset values: `tx_data`=0, `tx_start`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wmask`=0, `mem_rstrb`=0, `hold`=0, `overrun`=0. State is IDLE, counters are 0.
- Reset asserted mid-frame or mid-transaction aborts immediately. All strobes drop asynchronously.
- Write: the cycle after the D3 strobe, `mem_wmask`=F. `mem_addr`/`mem_wdata` are stable from that cycle until WWAIT exits.
- Read: the cycle after the A3 strobe, `mem_rstrb`=1. With `mem_rbusy`=0, data is latched on the next cycle.
- `tx_start` is issued only when `tx_busy`=0 and no `tx_start` occurred in the previous cycle. This covers transmitters that raise busy one cycle late.
- `tx_data` is stable from the `tx_start` cycle until the next byte is loaded.
- `hold` rises the cycle after the command byte strobe. It falls the cycle after the last `tx_start`, or on timeout.

## Structure
- Package `ubm_pkg`:
  - command codes CMD_W=8'h57 and CMD_R=8'h52;
  - state enum (IDLE, ADDR, DATA, WR, WWAIT, RD, RWAIT, NAK, SEND);
  - byte count width.
- Sub-module `ubm_gap_timer`: loadable down-counter with enable, reload and an expired flag, parameterised by `TIMEOUT`.

## Test plan
- Write frame 57 04 00 00 00 EF BE AD DE → one cycle of `mem_wmask`=F with `mem_addr`=0x00000004, `mem_wdata`=0xDEADBEEF. Then `tx_data`=06 sent once.
- Read 0x00000004 with a memory model returning 0xDEADBEEF and `mem_rbusy` high for 3 cycles → exactly one `mem_rstrb` pulse; reply bytes EF BE AD DE in order.
- Address byte 07 in A0 → `mem_addr`=0x00000004.
- Command byte 41 → `tx_data`=15; `hold` returns to 0; no bus strobe.
- Write frame stalled after A1 for `TIMEOUT`+1 cycles → back to IDLE, no strobe, no reply. A subsequent valid read succeeds.
- Two extra `rx_valid` strobes during SEND → `overrun`=1, reply unaffected.
- With `tx_busy` asserted one cycle late, no byte is skipped or duplicated.
- `resetn` pulsed low during WWAIT → all outputs return to reset values within the same cycle.
